// File: rtl/ahb_gpio_if.sv
// AHB-Lite slave-side bus bundle for the GPIO peripheral.
// Groups the address/data phase signals behind master/slave views.
interface ahb_gpio_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic        HWRITE;
    logic        HREADY;
    logic [31:0] HWDATA;
    logic        HREADYOUT;
    logic [31:0] HRDATA;
    logic        HRESP;

    modport master (
        output HSEL, HADDR, HTRANS, HSIZE, HWRITE, HREADY, HWDATA,
        input  HREADYOUT, HRDATA, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HSIZE, HWRITE, HREADY, HWDATA,
        output HREADYOUT, HRDATA, HRESP
    );
endinterface

// File: rtl/ahb_gpio.sv
// Zero-wait AHB-Lite GPIO: direction, set/clear/toggle outputs,
// synchronised inputs and edge interrupts with W1C status.
module ahb_gpio #(
    parameter int GPIO_WIDTH  = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    ahb_gpio_if.slave             bus,
    input  logic [GPIO_WIDTH-1:0] GPIO_IN,
    output logic [GPIO_WIDTH-1:0] GPIO_OUT,
    output logic [GPIO_WIDTH-1:0] GPIO_OE,
    output logic                  IRQ
);
    localparam int W = GPIO_WIDTH;

    localparam logic [3:0] A_DOUT = 4'h0;
    localparam logic [3:0] A_DIN  = 4'h1;
    localparam logic [3:0] A_DIR  = 4'h2;
    localparam logic [3:0] A_SET  = 4'h3;
    localparam logic [3:0] A_CLR  = 4'h4;
    localparam logic [3:0] A_TGL  = 4'h5;
    localparam logic [3:0] A_REN  = 4'h6;
    localparam logic [3:0] A_FEN  = 4'h7;
    localparam logic [3:0] A_STS  = 4'h8;

    logic         act_q;
    logic         wr_q;
    logic [3:0]   addr_q;
    logic         accept;
    logic         wr_en;
    logic         rd_en;
    logic [W-1:0] wdata;

    logic [W-1:0] dout_q, dout_d;
    logic [W-1:0] dir_q, dir_d;
    logic [W-1:0] ren_q, ren_d;
    logic [W-1:0] fen_q, fen_d;
    logic [W-1:0] sts_q, sts_d;
    logic [W-1:0] w1c;
    logic [W-1:0] rd_w;

    logic [W-1:0] sync_q [SYNC_STAGES];
    logic [W-1:0] s;
    logic [W-1:0] p_q;
    logic [W-1:0] rise;
    logic [W-1:0] fall;

    logic unused_ok;
    assign unused_ok = ^{bus.HSIZE, bus.HADDR[31:6], bus.HADDR[1:0],
                         bus.HTRANS[0], bus.HWDATA};

    assign accept = bus.HSEL & bus.HREADY & bus.HTRANS[1];
    assign wr_en  = act_q & wr_q & bus.HREADY;
    assign rd_en  = act_q & ~wr_q;
    assign wdata  = bus.HWDATA[W-1:0];

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            act_q  <= 1'b0;
            wr_q   <= 1'b0;
            addr_q <= '0;
        end else if (bus.HREADY) begin
            act_q  <= accept;
            wr_q   <= bus.HWRITE;
            addr_q <= bus.HADDR[5:2];
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            p_q <= '0;
        end else begin
            sync_q[0] <= GPIO_IN;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            p_q <= s;
        end
    end

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~p_q & ren_q;
    assign fall = ~s & p_q & fen_q;

    always_comb begin
        dout_d = dout_q;
        dir_d  = dir_q;
        ren_d  = ren_q;
        fen_d  = fen_q;
        w1c    = '0;
        if (wr_en) begin
            case (addr_q)
                A_DOUT:  dout_d = wdata;
                A_DIR:   dir_d  = wdata;
                A_SET:   dout_d = dout_q | wdata;
                A_CLR:   dout_d = dout_q & ~wdata;
                A_TGL:   dout_d = dout_q ^ wdata;
                A_REN:   ren_d  = wdata;
                A_FEN:   fen_d  = wdata;
                A_STS:   w1c    = wdata;
                default: ;
            endcase
        end
        // a fresh edge event outranks a same-cycle clear
        sts_d = (sts_q & ~w1c) | rise | fall;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dout_q <= '0;
            dir_q  <= '0;
            ren_q  <= '0;
            fen_q  <= '0;
            sts_q  <= '0;
        end else begin
            dout_q <= dout_d;
            dir_q  <= dir_d;
            ren_q  <= ren_d;
            fen_q  <= fen_d;
            sts_q  <= sts_d;
        end
    end

    always_comb begin
        rd_w = '0;
        if (rd_en) begin
            case (addr_q)
                A_DOUT:  rd_w = dout_q;
                A_DIN:   rd_w = s;
                A_DIR:   rd_w = dir_q;
                A_REN:   rd_w = ren_q;
                A_FEN:   rd_w = fen_q;
                A_STS:   rd_w = sts_q;
                default: rd_w = '0;
            endcase
        end
    end

    assign bus.HRDATA    = 32'(rd_w);
    assign bus.HREADYOUT = 1'b1;
    assign bus.HRESP     = 1'b0;

    assign GPIO_OUT = dout_q;
    assign GPIO_OE  = dir_q;
    assign IRQ      = |sts_q;
endmodule

// File: tb/tb_ahb_gpio.sv
// Directed bench for ahb_gpio with GPIO_WIDTH=8, SYNC_STAGES=2.
// Bus helpers start and end on a falling clock edge.
module tb_ahb_gpio;
    localparam int W = 8;
    localparam int SYNC = 2;

    logic         HCLK;
    logic         HRESETn;
    logic [W-1:0] gpio_in;
    logic [W-1:0] gpio_out;
    logic [W-1:0] gpio_oe;
    logic         irq;
    int           nvec;
    int           nerr;
    logic [31:0]  rd;

    ahb_gpio_if bus ();

    ahb_gpio #(
        .GPIO_WIDTH  (W),
        .SYNC_STAGES (SYNC)
    ) dut (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .bus      (bus),
        .GPIO_IN  (gpio_in),
        .GPIO_OUT (gpio_out),
        .GPIO_OE  (gpio_oe),
        .IRQ      (irq)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic bus_idle();
        bus.HSEL   = 1'b0;
        bus.HTRANS = 2'b00;
        bus.HWRITE = 1'b0;
        bus.HADDR  = '0;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        bus.HSEL   = 1'b1;
        bus.HTRANS = 2'b10;
        bus.HWRITE = 1'b1;
        bus.HADDR  = a;
        @(negedge HCLK);
        bus_idle();
        bus.HWDATA = d;
        @(negedge HCLK);
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        bus.HSEL   = 1'b1;
        bus.HTRANS = 2'b10;
        bus.HWRITE = 1'b0;
        bus.HADDR  = a;
        @(negedge HCLK);
        d = bus.HRDATA;
        bus_idle();
    endtask

    task automatic wait_n(input int n);
        for (int i = 0; i < n; i++) @(negedge HCLK);
    endtask

    task automatic test_reset();
        HRESETn = 1'b0;
        wait_n(2);
        nvec++;
        if (gpio_out !== 8'h00 || gpio_oe !== 8'h00) begin
            nerr++;
            $display("FAIL reset_pins: out=%h oe=%h want 00/00", gpio_out, gpio_oe);
        end
        nvec++;
        if (irq !== 1'b0 || bus.HRDATA !== 32'h0) begin
            nerr++;
            $display("FAIL reset_irq_rdata: irq=%b hrdata=%h want 0/0", irq, bus.HRDATA);
        end
        HRESETn = 1'b1;
        wait_n(1);
        bus_read(32'h00, rd);
        nvec++;
        if (rd !== 32'h0) begin
            nerr++;
            $display("FAIL reset_read_dout: got %h want 00000000", rd);
        end
        wait_n(1);
    endtask

    task automatic test_outputs();
        bus_write(32'h00, 32'hF0);
        nvec++;
        if (gpio_out !== 8'hF0) begin
            nerr++;
            $display("FAIL out_write: got %h want f0", gpio_out);
        end
        bus_write(32'h0C, 32'h03);
        nvec++;
        if (gpio_out !== 8'hF3) begin
            nerr++;
            $display("FAIL out_set: got %h want f3", gpio_out);
        end
        bus_write(32'h10, 32'h80);
        nvec++;
        if (gpio_out !== 8'h73) begin
            nerr++;
            $display("FAIL out_clr: got %h want 73", gpio_out);
        end
        bus_write(32'h14, 32'hFF);
        nvec++;
        if (gpio_out !== 8'h8C) begin
            nerr++;
            $display("FAIL out_tgl: got %h want 8c", gpio_out);
        end
        bus_write(32'h00, 32'hFFFF_FFFF);
        bus_read(32'h00, rd);
        nvec++;
        if (rd !== 32'h0000_00FF) begin
            nerr++;
            $display("FAIL out_width_mask: got %h want 000000ff", rd);
        end
        wait_n(1);
        nvec++;
        if (bus.HRDATA !== 32'h0) begin
            nerr++;
            $display("FAIL idle_rdata: got %h want 00000000", bus.HRDATA);
        end
    endtask

    task automatic test_inputs();
        gpio_in = 8'h5A;
        wait_n(SYNC);
        bus_read(32'h04, rd);
        nvec++;
        if (rd !== 32'h0000_005A) begin
            nerr++;
            $display("FAIL data_in: got %h want 0000005a", rd);
        end
        bus_read(32'h0C, rd);
        nvec++;
        if (rd !== 32'h0) begin
            nerr++;
            $display("FAIL read_wo: got %h want 00000000", rd);
        end
        bus_read(32'h30, rd);
        nvec++;
        if (rd !== 32'h0 || bus.HRESP !== 1'b0) begin
            nerr++;
            $display("FAIL read_reserved: got %h resp=%b want 0/0", rd, bus.HRESP);
        end
        wait_n(1);
    endtask

    task automatic test_irq();
        bus_write(32'h18, 32'h01);
        bus_write(32'h1C, 32'h02);
        gpio_in = 8'h59;
        wait_n(SYNC);
        nvec++;
        if (irq !== 1'b0) begin
            nerr++;
            $display("FAIL irq_early: got %b want 0", irq);
        end
        wait_n(1);
        nvec++;
        if (irq !== 1'b1) begin
            nerr++;
            $display("FAIL irq_rise: got %b want 1", irq);
        end
        bus_read(32'h20, rd);
        nvec++;
        if (rd !== 32'h03) begin
            nerr++;
            $display("FAIL irq_status: got %h want 00000003", rd);
        end
        wait_n(1);
        bus_write(32'h20, 32'h01);
        bus_read(32'h20, rd);
        nvec++;
        if (rd !== 32'h02 || irq !== 1'b1) begin
            nerr++;
            $display("FAIL w1c_bit0: sts=%h irq=%b want 02/1", rd, irq);
        end
        wait_n(1);
        bus_write(32'h20, 32'h02);
        nvec++;
        if (irq !== 1'b0) begin
            nerr++;
            $display("FAIL w1c_bit1: irq=%b want 0", irq);
        end
    endtask

    task automatic test_collision();
        gpio_in = 8'h58;
        wait_n(4);
        gpio_in = 8'h59;
        wait_n(SYNC + 1);
        nvec++;
        if (irq !== 1'b1) begin
            nerr++;
            $display("FAIL coll_prep: irq=%b want 1", irq);
        end
        gpio_in = 8'h58;
        wait_n(4);
        gpio_in = 8'h59;
        wait_n(1);
        bus_write(32'h20, 32'h01);
        bus_read(32'h20, rd);
        nvec++;
        if (rd !== 32'h01) begin
            nerr++;
            $display("FAIL set_beats_clear: sts=%h want 00000001", rd);
        end
        wait_n(1);
        bus_write(32'h20, 32'h01);
        nvec++;
        if (irq !== 1'b0) begin
            nerr++;
            $display("FAIL coll_cleanup: irq=%b want 0", irq);
        end
    endtask

    task automatic test_back_to_back();
        bus.HSEL   = 1'b1;
        bus.HTRANS = 2'b10;
        bus.HWRITE = 1'b1;
        bus.HADDR  = 32'h08;
        @(negedge HCLK);
        bus.HWDATA = 32'hAA;
        bus.HWRITE = 1'b0;
        bus.HADDR  = 32'h08;
        @(negedge HCLK);
        bus_idle();
        nvec++;
        if (bus.HRDATA !== 32'h0000_00AA || bus.HREADYOUT !== 1'b1) begin
            nerr++;
            $display("FAIL b2b_read: got %h rdy=%b want 000000aa/1",
                     bus.HRDATA, bus.HREADYOUT);
        end
        nvec++;
        if (gpio_oe !== 8'hAA) begin
            nerr++;
            $display("FAIL b2b_oe: got %h want aa", gpio_oe);
        end
        wait_n(1);
    endtask

    task automatic test_reset_mid();
        gpio_in = 8'h58;
        wait_n(4);
        gpio_in = 8'h59;
        wait_n(SYNC + 1);
        nvec++;
        if (irq !== 1'b1) begin
            nerr++;
            $display("FAIL rst_prep_irq: got %b want 1", irq);
        end
        bus.HSEL   = 1'b1;
        bus.HTRANS = 2'b10;
        bus.HWRITE = 1'b0;
        bus.HADDR  = 32'h00;
        @(negedge HCLK);
        bus_idle();
        nvec++;
        if (bus.HRDATA !== 32'h0000_00FF) begin
            nerr++;
            $display("FAIL rst_prep_read: got %h want 000000ff", bus.HRDATA);
        end
        HRESETn = 1'b0;
        #1;
        nvec++;
        if (gpio_out !== 8'h00 || gpio_oe !== 8'h00 || irq !== 1'b0) begin
            nerr++;
            $display("FAIL rst_mid_pins: out=%h oe=%h irq=%b want 00/00/0",
                     gpio_out, gpio_oe, irq);
        end
        nvec++;
        if (bus.HRDATA !== 32'h0) begin
            nerr++;
            $display("FAIL rst_mid_rdata: got %h want 00000000", bus.HRDATA);
        end
        @(negedge HCLK);
        HRESETn = 1'b1;
        bus_read(32'h00, rd);
        nvec++;
        if (rd !== 32'h0) begin
            nerr++;
            $display("FAIL rst_mid_dout: got %h want 00000000", rd);
        end
        wait_n(SYNC + 3);
        nvec++;
        if (irq !== 1'b0) begin
            nerr++;
            $display("FAIL rst_held_pin_irq: got %b want 0", irq);
        end
        bus_read(32'h04, rd);
        nvec++;
        if (rd !== 32'h59) begin
            nerr++;
            $display("FAIL rst_data_in: got %h want 00000059", rd);
        end
        wait_n(1);
    endtask

    initial begin
        nvec       = 0;
        nerr       = 0;
        HRESETn    = 1'b0;
        gpio_in    = '0;
        bus.HSIZE  = 3'b010;
        bus.HREADY = 1'b1;
        bus.HWDATA = '0;
        bus_idle();
        test_reset();
        test_outputs();
        test_inputs();
        test_irq();
        test_collision();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/ahb_gpio.md
# ahb_gpio

Parametrised AHB-Lite general-purpose I/O slave, the next generation of the single-register PIO peripheral. It provides per-pin direction control, atomic set/clear/toggle of outputs, synchronised input sampling, and edge-triggered interrupts with write-1-to-clear status. It sits on the SOPC AHB bus as a zero-wait-state slave and drives the board GPIO pads through external tri-state buffers.

## Interface
Parameters:
- GPIO_WIDTH, 32, number of pins (1..32); register bits at and above GPIO_WIDTH read 0 and ignore writes.
- SYNC_STAGES, 2, input synchroniser depth (2..4).

Ports:
- HCLK  in  1  bus clock; all state on rising edge.
- HRESETn  in  1  reset, asynchronous, active-low.
- HSEL  in  1  slave select.
- HADDR  in  32  address; only HADDR[5:2] decoded.
- HTRANS  in  2  transfer type; HTRANS[1]=1 means NONSEQ/SEQ.
- HSIZE  in  3  ignored; every write is a full 32-bit write.
- HWRITE  in  1  1=write.
- HREADY  in  1  bus ready; address phase is accepted only when high.
- HWDATA  in  32  write data (data phase).
- HREADYOUT  out  1  constant 1.
- HRDATA  out  32  read data (data phase).
- HRESP  out  1  constant 0 (OKAY).
- GPIO_IN  in  GPIO_WIDTH  asynchronous pad inputs.
- GPIO_OUT  out  GPIO_WIDTH  output data, equal to DATA_OUT.
- GPIO_OE  out  GPIO_WIDTH  output enable, equal to DIR; 1 = drive.
- IRQ  out  1  interrupt request, active-high level.

## Operation
- Transfer accepted when HSEL & HREADY & HTRANS[1]. HADDR[5:2] and HWRITE are registered in that address phase. The access executes in the following data phase.
- Register map (byte offset):
  - 0x00 DATA_OUT: RW.
  - 0x04 DATA_IN: RO, synchroniser output.
  - 0x08 DIR: RW.
  - 0x0C OUT_SET: WO, DATA_OUT |= wdata.
  - 0x10 OUT_CLR: WO, DATA_OUT &= ~wdata.
  - 0x14 OUT_TGL: WO, DATA_OUT ^= wdata.
  - 0x18 RISE_EN: RW.
  - 0x1C FALL_EN: RW.
  - 0x20 IRQ_STATUS: RW1C.
  - 0x24 to 0x3C: reserved. Reads return 0; writes are ignored; response is OKAY.
- Reads of write-only registers return 0.
- Input path: GPIO_IN passes through SYNC_STAGES flops to give s, plus one flop p holding s from the previous cycle.
  - rise = s & ~p & RISE_EN.
  - fall = ~s & p & FALL_EN.
- IRQ_STATUS[i] is set on rise[i] or fall[i] and cleared by writing 1. If a set and a clear hit the same bit in the same cycle, the set wins.
- Clearing RISE_EN or FALL_EN never clears IRQ_STATUS.
- IRQ = |IRQ_STATUS, combinational from the status register.

## Timing
- Zero wait states; HREADYOUT=1 and HRESP=0 always.
- Write: the register updates on the rising edge that ends the data phase, using HWDATA sampled in that data phase.
- Read: HRDATA is driven combinationally during the data phase from the registered address and the current register contents. HRDATA=0 in any cycle that is not a read data phase.
- Back-to-back write then read of the same register returns the new value, because the write lands at the edge where the read data phase begins.
- Input latency:
  - A GPIO_IN change stable before edge 1 is visible in DATA_IN after edge SYNC_STAGES.
  - The matching IRQ_STATUS bit and IRQ assert after edge SYNC_STAGES+1.
- Output latency: GPIO_OUT and GPIO_OE change on the same edge as the register write.
- Reset (asynchronous, any time, including mid-transfer):
  - All registers, synchroniser flops, p, and the registered address are cleared to 0.
  - GPIO_OUT=0, GPIO_OE=0 (all pins are inputs), IRQ=0, HRDATA=0.
  - Any in-flight transfer is dropped.
  - A pin held high through reset produces a rise event SYNC_STAGES+1 cycles after release. No status bit is set because RISE_EN=0.

## Test plan
- Reset with GPIO_WIDTH=8 -> GPIO_OUT=0x00, GPIO_OE=0x00, IRQ=0, HRDATA=0; read 0x00 -> 0x00000000.
- Write 0x00=0xF0, write 0x0C=0x03, write 0x10=0x80, write 0x14=0xFF -> GPIO_OUT is 0xF0, then 0xF3, then 0x73, then 0x8C; write 0x00=0xFFFF_FFFF then read -> 0x000000FF.
- Drive GPIO_IN=0x5A, wait SYNC_STAGES cycles, read 0x04 -> 0x0000005A; a read of 0x0C returns 0; a read of 0x30 returns 0 with HRESP=0.
- Set RISE_EN=0x01 and FALL_EN=0x02; pulse pin0 0->1 and pin1 1->0 -> IRQ rises SYNC_STAGES+1 cycles later with IRQ_STATUS=0x03; write 0x20=0x01 -> status 0x02 and IRQ stays 1; write 0x20=0x02 -> IRQ=0.
- Force a pin0 rising edge in the same cycle as a W1C of bit0 -> IRQ_STATUS[0] remains 1.
- Back-to-back write 0x08=0xAA then read 0x08 -> HRDATA=0x000000AA with no wait state; assert HRESETn=0 mid-transfer -> all outputs return to their reset values immediately.
